// File: rtl/risc_pkg.sv
// Shared definitions for the multicycle core: opcode constants, controller
// state/select encodings and the legal-opcode check used by DECODE.
package risc_pkg;

  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OPCODE_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPCODE_I_ALU  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPCODE_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_TARGET = 2'd1,
    PC_JALR   = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ILLEGAL  = 2'd1,
    CAUSE_FETCH_TO = 2'd2,
    CAUSE_MEM_TO   = 2'd3
  } trap_cause_t;

  // True for every opcode the controller knows how to sequence.
  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    logic legal;
    case (op)
      OPCODE_R, OPCODE_I_ALU, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH,
      OPCODE_JAL, OPCODE_JALR, OPCODE_LUI, OPCODE_AUIPC: legal = 1'b1;
      default:                                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles and flags the last one allowed.
//   clk, rst_n : clock, async active-low reset
//   enable     : request outstanding and ready low this cycle
//   clear      : controller changes state this cycle; counter restarts
//   expired    : this stalled cycle is the MEM_TIMEOUT-th one (never when MEM_TIMEOUT=0)
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Wait counter; with MEM_TIMEOUT=0 it may wrap, which is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && enable && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32-style control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB],
// with a sticky TRAP for illegal opcodes and memory timeouts.
//   clk, rst_n          : clock, async active-low reset
//   opcode              : opcode from the decoder (held stable by the IR)
//   branch_taken        : ALU compare result, sampled in EXEC
//   imem_req/imem_ready : instruction fetch handshake
//   dmem_req/dmem_we/dmem_ready : data access handshake
//   ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, rf_we, wb_sel : datapath strobes
//   state, trap, trap_cause : status
// Strobes are combinational from state and inputs; state and cause are registered.
module multicycle_ctrl
  import risc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic [2:0] state,
  output logic       trap,
  output logic [1:0] trap_cause
);

  ctrl_state_t state_q, next_state;
  trap_cause_t cause_q, next_cause;
  pc_sel_t     pc_sel_c;
  wb_sel_t     wb_sel_c;
  logic        timer_en, timer_clear, timer_expired;

  // Stall cycles are counted only while a request is waiting on ready.
  assign timer_en    = ((state_q == ST_FETCH) && !imem_ready) ||
                       ((state_q == ST_MEM)   && !dmem_ready);
  assign timer_clear = (next_state != state_q);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (timer_en),
    .clear   (timer_clear),
    .expired (timer_expired)
  );

  // State and trap cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= next_state;
      cause_q <= next_cause;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    next_state = state_q;
    next_cause = cause_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel_c   = PC_PLUS4;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 1'b0;
    rf_we      = 1'b0;
    wb_sel_c   = WB_ALU;

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we      = 1'b1;
          next_state = ST_DECODE;
        end else if (timer_expired) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_FETCH_TO;
        end
      end

      ST_DECODE: begin
        if (is_legal(opcode)) begin
          next_state = ST_EXEC;
        end else begin
          next_state = ST_TRAP;
          next_cause = CAUSE_ILLEGAL;
        end
      end

      ST_EXEC: begin
        // Branch compares rs1/rs2; its target comes from the PC+imm adder via pc_sel.
        alu_a_sel = (opcode == OPCODE_AUIPC) || (opcode == OPCODE_JAL);
        alu_b_sel = !((opcode == OPCODE_R) || (opcode == OPCODE_BRANCH));
        case (opcode)
          OPCODE_BRANCH: begin
            pc_we      = 1'b1;
            pc_sel_c   = branch_taken ? PC_TARGET : PC_PLUS4;
            next_state = ST_FETCH;
          end
          OPCODE_LOAD, OPCODE_STORE: next_state = ST_MEM;
          default:                   next_state = ST_WB;
        endcase
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OPCODE_STORE);
        if (dmem_ready) begin
          if (opcode == OPCODE_STORE) begin
            pc_we      = 1'b1;
            next_state = ST_FETCH;
          end else begin
            next_state = ST_WB;
          end
        end else if (timer_expired) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_MEM_TO;
        end
      end

      ST_WB: begin
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        next_state = ST_FETCH;
        case (opcode)
          OPCODE_LOAD: wb_sel_c = WB_MEM;
          OPCODE_JAL:  begin wb_sel_c = WB_PC4; pc_sel_c = PC_TARGET; end
          OPCODE_JALR: begin wb_sel_c = WB_PC4; pc_sel_c = PC_JALR;   end
          default:     wb_sel_c = WB_ALU;
        endcase
      end

      ST_TRAP: next_state = ST_TRAP;

      default: next_state = ST_FETCH;
    endcase

    // Nothing may strobe while reset is held, even though FETCH is the reset state.
    if (!rst_n) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel_c  = PC_PLUS4;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      rf_we     = 1'b0;
      wb_sel_c  = WB_ALU;
    end
  end

  assign pc_sel     = pc_sel_c;
  assign wb_sel     = wb_sel_c;
  assign state      = state_q;
  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max wait cycles per memory request (0 = no timeout).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port opcode  in  7  opcode field from the decoder.
REQ-005 SHALL have port branch_taken  in  1  branch comparison result from the ALU, valid in EXEC.
REQ-006 SHALL have port imem_req  out  1  instruction fetch request.
REQ-007 SHALL have port imem_ready  in  1  fetch data valid this cycle.
REQ-008 SHALL have port dmem_req  out  1  data memory request.
REQ-009 SHALL have port dmem_we  out  1  data memory write (store).
REQ-010 SHALL have port dmem_ready  in  1  data access complete this cycle.
REQ-011 SHALL have port ir_we  out  1  instruction register load strobe.
REQ-012 SHALL have port pc_we  out  1  PC update strobe.
REQ-013 SHALL have port pc_sel  out  2  PC source: PLUS4, TARGET (PC+imm), JALR ((rs1+imm)&~1).
REQ-014 SHALL have port alu_a_sel  out  1  ALU A operand: 0=rs1, 1=PC.
REQ-015 SHALL have port alu_b_sel  out  1  ALU B operand: 0=rs2, 1=immediate.
REQ-016 SHALL have port rf_we  out  1  register file write strobe.
REQ-017 SHALL have port wb_sel  out  2  writeback source: ALU, MEM, PC4.
REQ-018 SHALL have port state  out  3  current FSM state.
REQ-019 SHALL have port trap  out  1  controller halted in TRAP.
REQ-020 SHALL have port trap_cause  out  2  NONE, ILLEGAL, FETCH_TO, MEM_TO.

Function
REQ-021 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, TRAP; all strobes combinational from state and inputs.
REQ-022 FETCH: imem_req=1; on imem_ready: ir_we=1, -> DECODE; else stay.
REQ-023 DECODE: legal opcodes are R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC -> EXEC; any other -> TRAP, cause ILLEGAL.
REQ-024 EXEC: R, I-ALU, LUI, AUIPC, JAL, JALR -> WB; LOAD/STORE -> MEM; BRANCH: pc_we=1, pc_sel=TARGET if branch_taken else PLUS4, -> FETCH.
REQ-025 EXEC operand selects: alu_a_sel=1 for AUIPC/JAL/BRANCH-target; alu_b_sel=1 for all except R and BRANCH compare.
REQ-026 MEM: dmem_req=1, dmem_we=1 only for STORE; on dmem_ready: STORE -> pc_we=1, pc_sel=PLUS4, -> FETCH; LOAD -> WB.
REQ-027 WB: rf_we=1, pc_we=1; wb_sel=MEM for LOAD, PC4 for JAL/JALR, else ALU; pc_sel=TARGET for JAL, JALR for JALR, else PLUS4; -> FETCH.
REQ-028 Wait counter SHALL count cycles with request high and ready low in FETCH/MEM, clearing on every state change.
REQ-029 When MEM_TIMEOUT>0 and counter reaches MEM_TIMEOUT-1 with ready low -> TRAP, cause FETCH_TO or MEM_TO; ready high that cycle wins (normal transition).
REQ-030 TRAP: trap=1, all strobes 0, state held until reset; trap_cause holds until reset.
REQ-031 rf_we, pc_we, ir_we, dmem_req SHALL each assert at most once per instruction (except req held while waiting).
REQ-032 Latency with zero-wait memory: BRANCH 3, ALU/JAL 4, STORE 4, LOAD 5 cycles.

Reset
REQ-033 While rst_n low: state=FETCH, counter=0, trap=0, trap_cause=NONE, all strobes 0.
REQ-034 Reset mid-instruction SHALL abort it with no further strobe; first cycle after release asserts imem_req.

Structure
REQ-035 ctrl_state_t, pc_sel_t, wb_sel_t, trap_cause_t SHALL live in risc_pkg beside the existing OPCODE_* constants.
REQ-036 Wait counter SHALL be sub-module mem_wait_timer (enable, clear, expired) parameterised by MEM_TIMEOUT.

Verification
REQ-037 ADD (0110011), imem_ready=1 immediately -> FETCH,DECODE,EXEC,WB in 4 cycles; WB rf_we=1, wb_sel=ALU, pc_sel=PLUS4.
REQ-038 LW (0000011), dmem_ready after 3 wait cycles -> MEM lasts 4 cycles, dmem_we=0, then WB with wb_sel=MEM.
REQ-039 SW (0100011) -> MEM with dmem_we=1, pc_we on ready, rf_we never 1.
REQ-040 BEQ (1100011), branch_taken=1 -> EXEC pc_we=1, pc_sel=TARGET, back in FETCH after 3 cycles; branch_taken=0 -> pc_sel=PLUS4.
REQ-041 Opcode 1110011 -> TRAP cause ILLEGAL, trap=1 and strobes 0 for 10 cycles; rst_n pulse low -> FETCH, cause NONE.
REQ-042 MEM_TIMEOUT=4, imem_ready held 0 -> TRAP FETCH_TO after 4 FETCH cycles; ready on 4th cycle -> DECODE, no trap.
